conv_stream_sequencer: RTL and testbench

//  Frame-level controller for the streaming MAC datapath (bias load, tap accumulate, output register).
//  Per output: fetch one bias beat, consume cfg_taps paired input/kernel beats, capture the result,

---
 rtl/conv_ctrl_pkg.sv | 15 +
 rtl/conv_stream_sequencer_term_counter.sv | 32 +++
 rtl/conv_stream_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_conv_stream_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and default widths for the convolution stream sequencer.
package conv_ctrl_pkg;

  localparam int TAP_W_DEF = 8;
  localparam int OUT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_MAC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_OUT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/conv_stream_sequencer_term_counter.sv
// Saturating up-counter that reports when it sits on a runtime terminal value.
module term_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         is_last
);

  logic [W-1:0] count_r;

  // Count up on inc; the terminal compare stops the counter from ever wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (inc && !is_last) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign is_last = (count_r == term);

endmodule

// File: rtl/conv_stream_sequencer.sv
// Frame controller for the streaming MAC datapath: per result it loads a bias,
// accumulates cfg_taps input/kernel pairs, captures the sum and streams it out.
module conv_stream_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [TAP_W-1:0] cfg_taps,
  input  logic [OUT_W-1:0] cfg_outputs,
  input  logic             i_TVALID,
  output logic             i_TREADY,
  input  logic             k_TVALID,
  output logic             k_TREADY,
  input  logic             b_TVALID,
  output logic             b_TREADY,
  output logic             o_TVALID,
  input  logic             o_TREADY,
  output logic             o_TLAST,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_en,
  output logic [TAP_W-1:0] tap_idx,
  output logic [OUT_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  seq_state_t       state_r;
  logic [TAP_W-1:0] taps_r;
  logic [OUT_W-1:0] outputs_r;
  logic             done_r;

  logic [TAP_W-1:0] tap_cnt_s;
  logic [TAP_W-1:0] tap_term_s;
  logic             tap_last_s;
  logic [OUT_W-1:0] out_cnt_s;
  logic [OUT_W-1:0] out_term_s;
  logic             out_last_s;
  logic             cfg_ok_s;
  logic             accept_s;
  logic             fire_s;
  logic             b_hs_s;
  logic             o_hs_s;
  logic             tap_clr_s;
  logic             tap_inc_s;
  logic             out_clr_s;
  logic             out_inc_s;

  // Transfer qualification and counter control; abort blocks every transfer.
  always_comb begin
    cfg_ok_s   = (cfg_taps != {TAP_W{1'b0}}) && (cfg_outputs != {OUT_W{1'b0}});
    tap_term_s = taps_r - {{(TAP_W-1){1'b0}}, 1'b1};
    out_term_s = outputs_r - {{(OUT_W-1){1'b0}}, 1'b1};
    if (abort) begin
      accept_s = 1'b0;
      fire_s   = 1'b0;
      b_hs_s   = 1'b0;
      o_hs_s   = 1'b0;
    end else begin
      accept_s = (state_r == ST_IDLE) && start && cfg_ok_s;
      fire_s   = (state_r == ST_MAC) && i_TVALID && k_TVALID;
      b_hs_s   = (state_r == ST_BIAS) && b_TVALID;
      o_hs_s   = (state_r == ST_OUT) && o_TREADY;
    end
    tap_clr_s = abort || accept_s || b_hs_s;
    tap_inc_s = fire_s;
    out_clr_s = abort || accept_s || (o_hs_s && out_last_s);
    out_inc_s = o_hs_s && !out_last_s;
  end

  term_counter #(.W(TAP_W)) u_tap_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (tap_clr_s),
    .inc     (tap_inc_s),
    .term    (tap_term_s),
    .count   (tap_cnt_s),
    .is_last (tap_last_s)
  );

  term_counter #(.W(OUT_W)) u_out_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (out_clr_s),
    .inc     (out_inc_s),
    .term    (out_term_s),
    .count   (out_cnt_s),
    .is_last (out_last_s)
  );

  // Frame state machine; cfg is latched so mid-frame changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      taps_r    <= {TAP_W{1'b0}};
      outputs_r <= {OUT_W{1'b0}};
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && cfg_ok_s) begin
              taps_r    <= cfg_taps;
              outputs_r <= cfg_outputs;
              state_r   <= ST_BIAS;
            end else if (start) begin
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_BIAS: state_r <= b_TVALID ? ST_MAC : ST_BIAS;
          ST_MAC: begin
            if (fire_s && tap_last_s) begin
              state_r <= ST_FLUSH;
            end else begin
              state_r <= ST_MAC;
            end
          end
          ST_FLUSH: state_r <= ST_OUT;
          ST_OUT: begin
            if (o_TREADY && out_last_s) begin
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else if (o_TREADY) begin
              state_r <= ST_BIAS;
            end else begin
              state_r <= ST_OUT;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // Output decode from the state register; readies never leave their own state.
  always_comb begin
    b_TREADY = 1'b0;
    i_TREADY = 1'b0;
    k_TREADY = 1'b0;
    o_TVALID = 1'b0;
    o_TLAST  = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    out_en   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        b_TREADY = 1'b0;
      end
      ST_BIAS: begin
        b_TREADY = !abort;
        acc_clr  = b_hs_s;
      end
      ST_MAC: begin
        i_TREADY = fire_s;
        k_TREADY = fire_s;
        acc_en   = fire_s;
      end
      ST_FLUSH: begin
        out_en = !abort;
      end
      ST_OUT: begin
        o_TVALID = 1'b1;
        o_TLAST  = out_last_s;
      end
      default: begin
        b_TREADY = 1'b0;
      end
    endcase
  end

  assign busy    = (state_r != ST_IDLE);
  assign done    = done_r;
  assign tap_idx = tap_cnt_s;
  assign out_idx = out_cnt_s;

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// Scoreboard bench: a behavioural MAC datapath driven by the sequencer's controls
// produces results that are checked against sums computed from generated frame data.
module tb_conv_stream_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] cfg_taps;
  logic [7:0] cfg_outputs;
  logic       i_TVALID, i_TREADY, k_TVALID, k_TREADY, b_TVALID, b_TREADY;
  logic       o_TVALID, o_TREADY, o_TLAST;
  logic       acc_clr, acc_en, out_en, busy, done;
  logic [7:0] tap_idx, out_idx;

  conv_stream_sequencer #(.TAP_W(8), .OUT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_taps(cfg_taps), .cfg_outputs(cfg_outputs),
    .i_TVALID(i_TVALID), .i_TREADY(i_TREADY),
    .k_TVALID(k_TVALID), .k_TREADY(k_TREADY),
    .b_TVALID(b_TVALID), .b_TREADY(b_TREADY),
    .o_TVALID(o_TVALID), .o_TREADY(o_TREADY), .o_TLAST(o_TLAST),
    .acc_clr(acc_clr), .acc_en(acc_en), .out_en(out_en),
    .tap_idx(tap_idx), .out_idx(out_idx), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int data;
    bit last;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   b_q[$];
  int   i_q[$];
  int   k_q[$];
  int   acc_m, oreg_m, acc_en_cnt;
  int   checks, errors;
  bit   rnd, b_hold, k_hold, o_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected results: bias plus the sum of input*kernel products of each output.
  function automatic void gen_frame(input int t, input int n);
    for (int o = 0; o < n; o++) begin
      int sum;
      int b;
      b = $urandom_range(0, 255);
      b_q.push_back(b);
      sum = b;
      for (int j = 0; j < t; j++) begin
        int a;
        int c;
        a = $urandom_range(0, 255);
        c = $urandom_range(0, 255);
        i_q.push_back(a);
        k_q.push_back(c);
        sum += a * c;
      end
      exp_q.push_back('{sum, (o == n - 1), o});
    end
  endfunction

  task automatic drive();
    b_TVALID = (b_q.size() > 0) && !b_hold && (!rnd || $urandom_range(0, 3) != 0);
    i_TVALID = (i_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
    k_TVALID = (k_q.size() > 0) && !k_hold && (!rnd || $urandom_range(0, 3) != 0);
    o_TREADY = !o_hold && (!rnd || $urandom_range(0, 2) != 0);
    if (rnd) begin
      cfg_taps    = 8'($urandom);
      cfg_outputs = 8'($urandom);
      start       = ($urandom_range(0, 7) == 0);
    end
  endtask

  // One clock: datapath model and stream sources act on the pre-edge values.
  task automatic step();
    #1;
    if (acc_clr && b_q.size() > 0) acc_m = b_q[0];
    if (acc_en) acc_en_cnt++;
    if (acc_en && i_q.size() > 0 && k_q.size() > 0) acc_m = acc_m + i_q[0] * k_q[0];
    if (out_en) oreg_m = acc_m;
    if (b_TVALID && b_TREADY && b_q.size() > 0) void'(b_q.pop_front());
    if (i_TVALID && i_TREADY && i_q.size() > 0) void'(i_q.pop_front());
    if (k_TVALID && k_TREADY && k_q.size() > 0) void'(k_q.pop_front());
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
  endtask

  task automatic start_frame(input int t, input int n);
    gen_frame(t, n);
    cfg_taps    = 8'(t);
    cfg_outputs = 8'(n);
    start       = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int bound);
    bit got;
    got = 1'b0;
    for (int n = 0; n < bound; n++) begin
      step();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk({name, "_done"}, got, 1);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  function automatic void flush_sources();
    b_q.delete();
    i_q.delete();
    k_q.delete();
    exp_q.delete();
  endfunction

  // Per-cycle expectation from the latency rule 1 + taps + 1 + 1 per output.
  function automatic logic [6:0] nom_exp(input int c, input int t, input int n);
    logic [6:0] v;
    int p;
    int o;
    v = 7'b0;
    if (c >= 1 && c <= n * (t + 3)) begin
      p = (c - 1) % (t + 3);
      o = (c - 1) / (t + 3);
      v = {p == 0, (p >= 1 && p <= t), p == t + 1, p == t + 2,
           (p == t + 2 && o == n - 1), 1'b0, 1'b1};
    end else if (c == n * (t + 3) + 1) begin
      v = 7'b0000010;
    end
    return v;
  endfunction

  // Monitor: scoreboard pops on every result handshake plus protocol rules.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        chk("ctrl_excl", 64'($countones({acc_clr, acc_en, out_en}) <= 1), 1);
        chk("ik_ready_pair", i_TREADY, k_TREADY);
        if (!busy) chk("idle_quiet", {b_TREADY, i_TREADY, k_TREADY, o_TVALID, acc_clr, acc_en, out_en}, 0);
        if (abort) chk("abort_ready", {b_TREADY, i_TREADY, k_TREADY}, 0);
        if (o_TVALID && o_TREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got result %0d expected none at %0t", oreg_m, $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data", oreg_m, e.data);
            chk("out_last", o_TLAST, e.last);
            chk("out_idx", out_idx, e.idx);
          end
        end
      end
    end
  end

  initial begin
    int n0;
    int w;
    checks = 0; errors = 0; acc_m = 0; oreg_m = 0; acc_en_cnt = 0;
    rnd = 0; b_hold = 0; k_hold = 0; o_hold = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_taps = 8'd0; cfg_outputs = 8'd0;
    b_TVALID = 1'b0; i_TVALID = 1'b0; k_TVALID = 1'b0; o_TREADY = 1'b0;
    step();
    step();
    chk("reset_state", {i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST, acc_clr, acc_en,
                        out_en, busy, done, tap_idx, out_idx}, 0);
    reset = 1'b0;
    step();
    chk("post_reset_idle", {busy, done, tap_idx, out_idx}, 0);

    // Nominal frame, all streams always ready.
    n0 = acc_en_cnt;
    start_frame(3, 2);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      chk($sformatf("nominal_c%0d", c),
          {b_TREADY, acc_en, out_en, o_TVALID, o_TLAST, done, busy}, nom_exp(c, 3, 2));
    end
    chk("nominal_acc_en_count", acc_en_cnt - n0, 6);
    chk("nominal_drain", exp_q.size(), 0);

    // Kernel stall at tap 1.
    start_frame(4, 1);
    step();
    chk("stall_pre", {acc_en, tap_idx}, {1'b1, 8'd0});
    k_hold = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("stall_hold", {i_TREADY, k_TREADY, acc_en, tap_idx}, {3'b000, 8'd1});
    end
    k_hold = 1'b0;
    run_until_done("stall", 100);

    // Result backpressure.
    o_hold = 1'b1;
    start_frame(2, 2);
    w = 0;
    while (!o_TVALID && w < 50) begin step(); w++; end
    chk("bp_reach_out", o_TVALID, 1);
    for (int s = 0; s < 5; s++) begin
      chk("bp_hold", {o_TVALID, o_TLAST, b_TREADY, acc_clr}, 4'b1000);
      step();
    end
    o_hold = 1'b0;
    run_until_done("bp", 100);

    // Degenerate shapes.
    cfg_taps = 8'd0; cfg_outputs = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("degen_taps_done", {done, busy}, 2'b10);
    step();
    chk("degen_taps_after", {done, busy}, 2'b00);
    cfg_taps = 8'd3; cfg_outputs = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("degen_outs_done", {done, busy}, 2'b10);

    // Abort during output 1, tap 2.
    start_frame(4, 2);
    w = 0;
    while (!(out_idx == 8'd1 && tap_idx == 8'd2 && acc_en) && w < 60) begin step(); w++; end
    chk("abort_reach", {out_idx, tap_idx, acc_en}, {8'd1, 8'd2, 1'b1});
    abort = 1'b1;
    #1;
    chk("abort_blocks", {i_TREADY, k_TREADY, acc_en}, 0);
    step();
    abort = 1'b0;
    chk("abort_idle", {busy, done, tap_idx, out_idx}, 0);
    chk("abort_out0_delivered", exp_q.size(), 1);
    flush_sources();
    step();
    chk("abort_no_done", {done, busy}, 0);
    rnd = 1'b1;
    start_frame(3, 3);
    run_until_done("post_abort", 2000);
    rnd = 1'b0;

    // Reset while a result is pending.
    o_hold = 1'b1;
    start_frame(1, 2);
    w = 0;
    while (!o_TVALID && w < 20) begin step(); w++; end
    chk("rst_reach_out", o_TVALID, 1);
    reset = 1'b1;
    #1;
    chk("rst_async", {o_TVALID, busy, b_TREADY, i_TREADY, k_TREADY, tap_idx, out_idx}, 0);
    step();
    reset = 1'b0;
    o_hold = 1'b0;
    flush_sources();
    step();
    chk("rst_idle", {busy, done, o_TVALID}, 0);

    // Boundary and randomized frames.
    start_frame(1, 1);
    run_until_done("one_tap", 50);
    rnd = 1'b1;
    start_frame(255, 1);
    run_until_done("max_taps", 3000);
    for (int f = 0; f < 6; f++) begin
      start_frame($urandom_range(1, 6), $urandom_range(1, 4));
      run_until_done($sformatf("rand%0d", f), 2000);
    end
    rnd = 1'b0;
    start = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
